div_issue_arbiter: RTL and testbench

- Shares the single shared integer divide unit (DIV/DIVU/REM/REMU) among NUM_REQ execute-stage requesters.
- Round-robin arbitration; owns the start/operand handshake to the divide unit.
- Holds the operands stable for the whole operation.
- Tags each result with its destination register and completion-buffer index, and buffers it until writeback accepts it.
- Supports pipeline flush.

---
 rtl/div_issue_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_div_issue_arbiter.sv | 510 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_arbiter.sv
// div_issue_arbiter
//   Shares one integer divide unit between NUM_REQ execute lanes. A round-robin
//   arbiter picks a lane while IDLE, the operands are registered on the grant
//   edge and held on du_* for the whole operation, and the result is buffered
//   together with its rd / completion-buffer tag until writeback takes it.
//   The divide unit cannot be aborted, so a flush during an operation parks
//   the block in DRAIN until du_done, and then the result is thrown away.
//
// Ports
//   CLK, nRST          clock, asynchronous active-low reset
//   flush              kill in-flight / pending divide work
//   req_*              per-lane request (lane 0 in the LSBs of packed buses)
//   req_ready          grant, one-hot or zero, only while IDLE
//   du_start/du_*      start pulse and held operands to the divide unit
//   du_done/du_wdata   divide-unit completion and result
//   resp_*             buffered tagged result, valid/ready handshake
//   busy               state != IDLE
module div_issue_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int CB_IDX_W = 3
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         flush,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [32*NUM_REQ-1:0]        req_rs1,
  input  logic [32*NUM_REQ-1:0]        req_rs2,
  input  logic [NUM_REQ-1:0]           req_signed,
  input  logic [NUM_REQ-1:0]           req_div_type,
  input  logic [5*NUM_REQ-1:0]         req_rd,
  input  logic [CB_IDX_W*NUM_REQ-1:0]  req_cb_idx,
  output logic                         du_start,
  output logic [31:0]                  du_rs1,
  output logic [31:0]                  du_rs2,
  output logic                         du_signed,
  output logic                         du_div_type,
  input  logic                         du_done,
  input  logic [31:0]                  du_wdata,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [31:0]                  resp_data,
  output logic [4:0]                   resp_rd,
  output logic [CB_IDX_W-1:0]          resp_cb_idx,
  output logic [$clog2(NUM_REQ)-1:0]   resp_lane,
  output logic                         busy
);

  localparam int LANE_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {IDLE, START, WAIT, RESP, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [LANE_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [31:0]         du_rs1_q, du_rs1_d, du_rs2_q, du_rs2_d;
  logic                du_signed_q, du_signed_d, du_div_type_q, du_div_type_d;
  logic [4:0]          rd_q, rd_d;
  logic [CB_IDX_W-1:0] cb_idx_q, cb_idx_d;
  logic [31:0]         resp_data_q, resp_data_d;

  // per-lane views of the packed request buses
  logic [NUM_REQ-1:0][31:0]         rs1_a, rs2_a;
  logic [NUM_REQ-1:0][4:0]          rd_a;
  logic [NUM_REQ-1:0][CB_IDX_W-1:0] cb_a;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign rs1_a[g] = req_rs1[g*32 +: 32];
    assign rs2_a[g] = req_rs2[g*32 +: 32];
    assign rd_a[g]  = req_rd[g*5 +: 5];
    assign cb_a[g]  = req_cb_idx[g*CB_IDX_W +: CB_IDX_W];
  end

  // round-robin pick: first valid lane at or after rr_ptr, wrapping upward
  int                idx;
  logic [LANE_W-1:0] cand;
  logic [LANE_W-1:0] grant_lane;
  logic              grant_found;
  logic              grant;

  always_comb begin
    idx         = 0;
    cand        = '0;
    grant_found = 1'b0;
    grant_lane  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx  = (int'(rr_ptr_q) + k) % NUM_REQ;
      cand = LANE_W'(idx);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_lane  = cand;
      end
    end
  end

  assign grant = (state_q == IDLE) && !flush && grant_found;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[grant_lane] = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    lane_d        = lane_q;
    du_rs1_d      = du_rs1_q;
    du_rs2_d      = du_rs2_q;
    du_signed_d   = du_signed_q;
    du_div_type_d = du_div_type_q;
    rd_d          = rd_q;
    cb_idx_d      = cb_idx_q;
    resp_data_d   = resp_data_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d       = START;
          rr_ptr_d      = LANE_W'((int'(grant_lane) + 1) % NUM_REQ);
          lane_d        = grant_lane;
          du_rs1_d      = rs1_a[grant_lane];
          du_rs2_d      = rs2_a[grant_lane];
          du_signed_d   = req_signed[grant_lane];
          du_div_type_d = req_div_type[grant_lane];
          rd_d          = rd_a[grant_lane];
          cb_idx_d      = cb_a[grant_lane];
        end
      end
      // START and WAIT differ only in du_start; du_done may already arrive
      // in START for the unit's early-out cases.
      START, WAIT: begin
        if (flush) begin
          state_d = du_done ? IDLE : DRAIN;
        end else if (du_done) begin
          resp_data_d = du_wdata;
          state_d     = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      // flush takes priority but both simply retire the entry
      RESP:    if (flush || resp_ready) state_d = IDLE;
      DRAIN:   if (du_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      lane_q        <= '0;
      du_rs1_q      <= '0;
      du_rs2_q      <= '0;
      du_signed_q   <= 1'b0;
      du_div_type_q <= 1'b0;
      rd_q          <= '0;
      cb_idx_q      <= '0;
      resp_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      lane_q        <= lane_d;
      du_rs1_q      <= du_rs1_d;
      du_rs2_q      <= du_rs2_d;
      du_signed_q   <= du_signed_d;
      du_div_type_q <= du_div_type_d;
      rd_q          <= rd_d;
      cb_idx_q      <= cb_idx_d;
      resp_data_q   <= resp_data_d;
    end
  end

  assign du_start    = (state_q == START);
  assign du_rs1      = du_rs1_q;
  assign du_rs2      = du_rs2_q;
  assign du_signed   = du_signed_q;
  assign du_div_type = du_div_type_q;
  assign resp_valid  = (state_q == RESP);
  assign resp_data   = resp_data_q;
  assign resp_rd     = rd_q;
  assign resp_cb_idx = cb_idx_q;
  assign resp_lane   = lane_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_div_issue_arbiter.sv
// Bench for div_issue_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model (grant queue, idle/response flags). A
// behavioural divide unit answers du_start after a programmable latency
// (0 = answer inside the start cycle).
module tb_div_issue_arbiter;
  localparam int N  = 2;
  localparam int CW = 3;
  localparam int LW = $clog2(N);

  logic              CLK, nRST, flush;
  logic [N-1:0]      req_valid, req_ready, req_signed, req_div_type;
  logic [32*N-1:0]   req_rs1, req_rs2;
  logic [5*N-1:0]    req_rd;
  logic [CW*N-1:0]   req_cb_idx;
  logic              du_start, du_signed, du_div_type, du_done;
  logic [31:0]       du_rs1, du_rs2, du_wdata;
  logic              resp_valid, resp_ready, busy;
  logic [31:0]       resp_data;
  logic [4:0]        resp_rd;
  logic [CW-1:0]     resp_cb_idx;
  logic [LW-1:0]     resp_lane;

  int n_tests = 0;
  int n_fail  = 0;
  int m_rr    = 0;

  // divide-unit model state
  int          du_lat  = 0;
  logic [31:0] du_res  = '0;
  logic [31:0] du_hold = '0;
  bit          du_busy = 0;
  int          du_cnt  = 0;

  typedef struct {
    logic [31:0]   rs1, rs2;
    logic          sg, dt;
    logic [4:0]    rd;
    logic [CW-1:0] cb;
    logic [LW-1:0] lane;
  } txn_t;

  div_issue_arbiter #(.NUM_REQ(N), .CB_IDX_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_signed(req_signed),
    .req_div_type(req_div_type), .req_rd(req_rd), .req_cb_idx(req_cb_idx),
    .du_start(du_start), .du_rs1(du_rs1), .du_rs2(du_rs2),
    .du_signed(du_signed), .du_div_type(du_div_type),
    .du_done(du_done), .du_wdata(du_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_cb_idx(resp_cb_idx), .resp_lane(resp_lane),
    .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int exp_grant(input logic [N-1:0] v, input int rr);
    for (int k = 0; k < N; k++)
      if (v[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int g);
    logic [N-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic set_lane(input int l, input logic [31:0] a, input logic [31:0] b,
                          input logic sg, input logic dt, input logic [4:0] rd,
                          input logic [CW-1:0] cb);
    req_rs1[l*32 +: 32]  = a;
    req_rs2[l*32 +: 32]  = b;
    req_signed[l]        = sg;
    req_div_type[l]      = dt;
    req_rd[l*5 +: 5]     = rd;
    req_cb_idx[l*CW +: CW] = cb;
  endtask

  // one evaluation per cycle: decide du_done for the current cycle
  task automatic du_eval();
    du_done  = 1'b0;
    du_wdata = 32'hDEAD_BEEF;
    if (du_busy) begin
      du_cnt--;
      if (du_cnt == 0) begin
        du_done  = 1'b1;
        du_wdata = du_hold;
        du_busy  = 0;
      end
    end else if (du_start) begin
      du_hold = du_res;
      if (du_lat == 0) begin
        du_done  = 1'b1;
        du_wdata = du_hold;
      end else begin
        du_busy = 1;
        du_cnt  = du_lat;
      end
    end
  endtask

  task automatic eval();
    du_eval();
    #1;
  endtask

  task automatic clk();
    @(posedge CLK);
    #1;
  endtask

  // run a just-granted operation to completion and accept it
  task automatic finish_op();
    bit ok;
    ok = 0;
    du_lat = 2; resp_ready = 1'b1; req_valid = '0; flush = 1'b0;
    for (int c = 0; c < 100; c++) begin
      du_res = $urandom;
      eval();
      if (resp_valid) ok = 1;
      clk();
      if (ok) break;
    end
    resp_ready = 1'b0;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL finish_op: no response within 100 cycles"); end
  endtask

  task automatic test_reset();
    nRST = 1'b0; flush = 1'b0; req_valid = '0; req_rs1 = '0; req_rs2 = '0;
    req_signed = '0; req_div_type = '0; req_rd = '0; req_cb_idx = '0;
    resp_ready = 1'b0; du_done = 1'b0; du_wdata = '0;
    repeat (3) @(posedge CLK);
    #1;
    n_tests++;
    if ({req_ready, du_start, du_signed, du_div_type, resp_valid, busy} !== '0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 0",
                         {req_ready, du_start, du_signed, du_div_type, resp_valid, busy});
    end
    n_tests++;
    if ({du_rs1, du_rs2, resp_data} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h required 0", {du_rs1, du_rs2, resp_data});
    end
    n_tests++;
    if ({resp_rd, resp_cb_idx, resp_lane} !== '0) begin
      n_fail++; $display("FAIL reset_tags: got %h required 0", {resp_rd, resp_cb_idx, resp_lane});
    end
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b required 0", busy); end
    m_rr = 0;
  endtask

  task automatic test_single();
    bit seen, early;
    seen = 0; early = 0;
    set_lane(0, 32'd100, 32'd7, 1'b0, 1'b1, 5'd3, 3'd2);
    req_valid = 2'b01; du_lat = 32; du_res = 32'd14;
    eval();
    n_tests++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_grant: got %b required 01", req_ready); end
    clk(); m_rr = 1; req_valid = '0;
    eval();
    n_tests++;
    if ({du_start, du_rs1, du_rs2, du_signed, du_div_type} !== {1'b1, 32'd100, 32'd7, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL single_start: start=%b rs1=%0d rs2=%0d required 1/100/7", du_start, du_rs1, du_rs2);
    end
    clk();
    for (int c = 1; c <= 40; c++) begin
      eval();
      if (c == 1) begin
        n_tests++;
        if (du_start !== 1'b0) begin n_fail++; $display("FAIL single_start_len: du_start=%b required 0", du_start); end
      end
      if (resp_valid) early = 1;
      if (du_done) begin seen = 1; clk(); break; end
      clk();
    end
    n_tests++;
    if (!seen || early) begin n_fail++; $display("FAIL single_wait: done_seen=%0d early_resp=%0d required 1/0", seen, early); end
    eval();
    n_tests++;
    if ({resp_valid, resp_data, resp_rd, resp_cb_idx, resp_lane} !== {1'b1, 32'd14, 5'd3, 3'd2, 1'b0}) begin
      n_fail++; $display("FAIL single_resp: valid=%b data=%0d rd=%0d cb=%0d lane=%0d required 1/14/3/2/0",
                         resp_valid, resp_data, resp_rd, resp_cb_idx, resp_lane);
    end
    resp_ready = 1'b1;
    clk(); resp_ready = 1'b0;
    eval();
    n_tests++;
    if ({busy, resp_valid} !== 2'b00) begin n_fail++; $display("FAIL single_retire: busy/valid=%b required 00", {busy, resp_valid}); end
    clk();
  endtask

  task automatic test_fast();
    set_lane(1, 32'h1234_5678, 32'd0, 1'b0, 1'b1, 5'd9, 3'd5);
    req_valid = 2'b10; du_lat = 0; du_res = 32'h7FFF_FFFF;
    eval();
    n_tests++;
    if (req_ready !== 2'b10) begin n_fail++; $display("FAIL fast_grant: got %b required 10", req_ready); end
    clk(); m_rr = 0; req_valid = '0;
    eval();
    n_tests++;
    if ({du_start, du_rs1, du_rs2} !== {1'b1, 32'h1234_5678, 32'd0}) begin
      n_fail++; $display("FAIL fast_start: start=%b rs1=%h rs2=%h required 1/12345678/0", du_start, du_rs1, du_rs2);
    end
    clk();
    eval();
    n_tests++;
    if ({resp_valid, resp_data, resp_rd, resp_cb_idx, resp_lane} !== {1'b1, 32'h7FFF_FFFF, 5'd9, 3'd5, 1'b1}) begin
      n_fail++; $display("FAIL fast_resp_cycle2: valid=%b data=%h lane=%0d required 1/7fffffff/1",
                         resp_valid, resp_data, resp_lane);
    end
    resp_ready = 1'b1;
    clk(); resp_ready = 1'b0;
    eval();
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL fast_retire: busy=%b required 0", busy); end
    clk();
  endtask

  task automatic test_rr();
    int ng, cur, e;
    int grants[4];
    bit twohot, outside;
    ng = 0; cur = -1; twohot = 0; outside = 0;
    set_lane(0, 32'd1000, 32'd3, 1'b1, 1'b0, 5'd1, 3'd1);
    set_lane(1, 32'd2000, 32'd5, 1'b0, 1'b1, 5'd2, 3'd6);
    req_valid = 2'b11; resp_ready = 1'b1; du_lat = 3;
    for (int c = 0; c < 200 && ng < 4; c++) begin
      du_res = $urandom;
      eval();
      if ($countones(req_ready) > 1) twohot = 1;
      if (busy && req_ready != '0) outside = 1;
      if (du_start) begin
        n_tests++;
        if (du_rs1 !== ((cur == 0) ? 32'd1000 : 32'd2000)) begin
          n_fail++; $display("FAIL rr_operand: du_rs1=%0d for lane %0d", du_rs1, cur);
        end
      end
      if (req_ready != '0) begin
        e = exp_grant(req_valid, m_rr);
        n_tests++;
        if (req_ready !== oh(e)) begin n_fail++; $display("FAIL rr_grant: got %b required %b", req_ready, oh(e)); end
        m_rr = (e + 1) % N;
        cur = req_ready[1] ? 1 : 0;
        grants[ng] = cur;
        ng++;
      end
      clk();
    end
    req_valid = '0;
    finish_op();
    n_tests++;
    if (ng != 4 || grants[0] != 0 || grants[1] != 1 || grants[2] != 0 || grants[3] != 1) begin
      n_fail++; $display("FAIL rr_sequence: %0d grants %0d%0d%0d%0d required 0101", ng,
                         grants[0], grants[1], grants[2], grants[3]);
    end
    n_tests++;
    if (twohot || outside) begin n_fail++; $display("FAIL rr_ready_shape: twohot=%0d outside_idle=%0d required 0/0", twohot, outside); end
  endtask

  task automatic test_backpressure();
    bit got, bad;
    int e;
    logic [31:0] saved;
    got = 0; bad = 0;
    set_lane(0, 32'd77, 32'd4, 1'b1, 1'b1, 5'd7, 3'd3);
    set_lane(1, 32'd88, 32'd2, 1'b0, 1'b0, 5'd8, 3'd4);
    req_valid = 2'b01; resp_ready = 1'b0; du_lat = 3; du_res = 32'hCAFE_0001;
    eval();
    n_tests++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_grant: got %b required 01", req_ready); end
    clk(); m_rr = 1; req_valid = 2'b11;
    for (int c = 0; c < 20; c++) begin
      eval();
      if (req_ready != '0) bad = 1;
      clk();
      if (resp_valid) begin got = 1; break; end
    end
    n_tests++;
    if (!got || bad) begin n_fail++; $display("FAIL bp_reach_resp: resp=%0d grant_while_busy=%0d required 1/0", got, bad); end
    saved = resp_data;
    n_tests++;
    if (saved !== 32'hCAFE_0001) begin n_fail++; $display("FAIL bp_data: got %h required cafe0001", saved); end
    for (int i = 0; i < 5; i++) begin
      eval();
      n_tests++;
      if ({resp_valid, resp_data, req_ready} !== {1'b1, saved, 2'b00}) begin
        n_fail++; $display("FAIL bp_hold: valid=%b data=%h ready=%b required 1/%h/00", resp_valid, resp_data, req_ready, saved);
      end
      clk();
    end
    resp_ready = 1'b1;
    eval();
    n_tests++;
    if ({resp_valid, req_ready} !== 3'b100) begin
      n_fail++; $display("FAIL bp_accept: valid=%b ready=%b required 1/00", resp_valid, req_ready);
    end
    clk(); resp_ready = 1'b0;
    eval();
    e = exp_grant(req_valid, m_rr);
    n_tests++;
    if ({busy, req_ready} !== {1'b0, oh(e)}) begin
      n_fail++; $display("FAIL bp_next_grant: busy=%b ready=%b required 0/%b", busy, req_ready, oh(e));
    end
    clk(); m_rr = (e + 1) % N; req_valid = '0;
    finish_op();
  endtask

  task automatic test_flush_wait();
    bit done, bad;
    done = 0; bad = 0;
    set_lane(0, 32'd500, 32'd9, 1'b0, 1'b0, 5'd11, 3'd1);
    req_valid = 2'b01; du_lat = 32; du_res = $urandom;
    eval();
    n_tests++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL flushw_grant: got %b required 01", req_ready); end
    clk(); m_rr = 1;
    eval(); clk();
    for (int k = 1; k <= 40; k++) begin
      flush = (k == 10 || k == 20);
      eval();
      if (resp_valid || req_ready != '0 || !busy) bad = 1;
      done = du_done;
      clk();
      if (done) break;
    end
    flush = 1'b0;
    n_tests++;
    if (!done || bad) begin n_fail++; $display("FAIL flushw_drain: done=%0d resp_or_grant_or_idle=%0d required 1/0", done, bad); end
    eval();
    n_tests++;
    if ({busy, resp_valid, req_ready} !== {1'b0, 1'b0, 2'b01}) begin
      n_fail++; $display("FAIL flushw_regrant: busy=%b valid=%b ready=%b required 0/0/01", busy, resp_valid, req_ready);
    end
    clk(); m_rr = 1; req_valid = '0;
    finish_op();
  endtask

  task automatic test_flush_resp();
    bit got, late;
    int e;
    got = 0; late = 0;
    // flush in IDLE blocks the grant
    set_lane(0, 32'd30, 32'd3, 1'b0, 1'b1, 5'd4, 3'd2);
    req_valid = 2'b01; flush = 1'b1;
    eval();
    n_tests++;
    if (req_ready !== 2'b00) begin n_fail++; $display("FAIL flush_idle: ready=%b required 00", req_ready); end
    clk(); flush = 1'b0;
    // flush together with resp_ready in RESP
    du_lat = 2;
    eval();
    e = exp_grant(req_valid, m_rr);
    n_tests++;
    if (req_ready !== oh(e)) begin n_fail++; $display("FAIL flushr_grant: got %b required %b", req_ready, oh(e)); end
    clk(); m_rr = (e + 1) % N; req_valid = '0;
    for (int c = 0; c < 10; c++) begin
      eval(); clk();
      if (resp_valid) begin got = 1; break; end
    end
    flush = 1'b1; resp_ready = 1'b1;
    eval(); clk();
    flush = 1'b0; resp_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      eval();
      if (resp_valid || busy) late = 1;
      clk();
    end
    n_tests++;
    if (!got || late) begin n_fail++; $display("FAIL flushr_resp: reached_resp=%0d resp_after_flush=%0d required 1/0", got, late); end
    // flush in START while the unit answers in the same cycle
    req_valid = 2'b10; du_lat = 0;
    set_lane(1, 32'd1, 32'd0, 1'b1, 1'b0, 5'd5, 3'd0);
    eval();
    e = exp_grant(req_valid, m_rr);
    clk(); m_rr = (e + 1) % N; req_valid = '0;
    flush = 1'b1;
    eval(); clk();
    flush = 1'b0;
    eval();
    n_tests++;
    if ({busy, resp_valid} !== 2'b00) begin n_fail++; $display("FAIL flush_start_fast: busy/valid=%b required 00", {busy, resp_valid}); end
    clk();
  endtask

  task automatic test_random();
    txn_t q[$];
    txn_t t;
    bit m_idle, m_resp, ok;
    logic [31:0] m_data;
    int g;
    m_idle = 1; m_resp = 0; m_data = '0; ok = 0;
    flush = 1'b0;
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      for (int l = 0; l < N; l++)
        set_lane(l, $urandom, $urandom, 1'($urandom), 1'($urandom), 5'($urandom), CW'($urandom));
      resp_ready = ($urandom_range(0, 2) != 0);
      du_lat = $urandom_range(0, 5);
      du_res = $urandom;
      eval();
      g = m_idle ? exp_grant(req_valid, m_rr) : -1;
      n_tests++;
      if (req_ready !== oh(g)) begin n_fail++; $display("FAIL rnd_grant: cycle %0d got %b required %b", c, req_ready, oh(g)); end
      n_tests++;
      if (resp_valid !== m_resp) begin n_fail++; $display("FAIL rnd_resp_valid: cycle %0d got %b required %b", c, resp_valid, m_resp); end
      if (du_start) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rnd_start: cycle %0d du_start with no granted op", c);
        end else if ({du_rs1, du_rs2, du_signed, du_div_type} !== {q[0].rs1, q[0].rs2, q[0].sg, q[0].dt}) begin
          n_fail++; $display("FAIL rnd_operands: cycle %0d got %h/%h required %h/%h", c, du_rs1, du_rs2, q[0].rs1, q[0].rs2);
        end
      end
      if (m_resp && resp_valid && q.size() != 0) begin
        n_tests++;
        if ({resp_data, resp_rd, resp_cb_idx, resp_lane} !== {m_data, q[0].rd, q[0].cb, q[0].lane}) begin
          n_fail++; $display("FAIL rnd_resp: cycle %0d data=%h rd=%0d cb=%0d lane=%0d required %h/%0d/%0d/%0d", c,
                             resp_data, resp_rd, resp_cb_idx, resp_lane, m_data, q[0].rd, q[0].cb, q[0].lane);
        end
      end
      if (g >= 0) begin
        t.rs1 = req_rs1[g*32 +: 32]; t.rs2 = req_rs2[g*32 +: 32];
        t.sg = req_signed[g]; t.dt = req_div_type[g];
        t.rd = req_rd[g*5 +: 5]; t.cb = req_cb_idx[g*CW +: CW]; t.lane = LW'(g);
        q.push_back(t);
        m_rr = (g + 1) % N;
        m_idle = 0;
      end
      if (m_resp && resp_ready) begin
        if (q.size() != 0) void'(q.pop_front());
        m_resp = 0;
        m_idle = 1;
      end
      if (du_done) begin
        m_data = du_wdata;
        m_resp = 1;
      end
      clk();
    end
    req_valid = '0; resp_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      eval();
      ok = !busy;
      clk();
      if (ok) break;
    end
    resp_ready = 1'b0;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL rnd_drain: still busy after 50 cycles"); end
  endtask

  task automatic test_reset_mid();
    set_lane(0, 32'd55, 32'd5, 1'b1, 1'b1, 5'd21, 3'd7);
    req_valid = 2'b01; du_lat = 30; du_res = 32'h55AA_55AA;
    eval();
    n_tests++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rstmid_grant: got %b required 01", req_ready); end
    clk(); m_rr = 1; req_valid = '0;
    repeat (6) begin eval(); clk(); end
    n_tests++;
    if ({busy, resp_rd} !== {1'b1, 5'd21}) begin n_fail++; $display("FAIL rstmid_wait: busy=%b rd=%0d required 1/21", busy, resp_rd); end
    nRST = 1'b0;
    #1;
    n_tests++;
    if ({req_ready, du_start, du_signed, du_div_type, resp_valid, busy} !== '0) begin
      n_fail++; $display("FAIL rstmid_ctrl: got %b required 0", {req_ready, du_start, du_signed, du_div_type, resp_valid, busy});
    end
    n_tests++;
    if ({du_rs1, du_rs2, resp_data, resp_rd, resp_cb_idx, resp_lane} !== '0) begin
      n_fail++; $display("FAIL rstmid_data: rs1=%h rs2=%h rd=%0d cb=%0d required 0", du_rs1, du_rs2, resp_rd, resp_cb_idx);
    end
    du_busy = 0; du_done = 1'b0; m_rr = 0;
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;
    req_valid = 2'b11;
    eval();
    n_tests++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rstmid_rrptr: got %b required 01", req_ready); end
    clk(); m_rr = 1; req_valid = '0;
    finish_op();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fast();
    test_rr();
    test_backpressure();
    test_flush_wait();
    test_flush_resp();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
